// File: rtl/intc_vectored.sv
// Vectored interrupt controller: N_SRC sources, fixed priority (0 highest), intr/inta handshake.
// Define INTC_NEST_EN for a STACK_DEPTH-deep in-service stack with preemption; otherwise one slot.
module intc_vectored #(
    parameter int          N_SRC       = 8,
    parameter int          STACK_DEPTH = 4,
    parameter logic [31:0] VEC_BASE    = 32'h0000_0020,
    parameter int          VEC_SHIFT   = 3
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             inta,
    input  logic             eret,
    input  logic             wen,
    input  logic [1:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             intr,
    output logic [4:0]       vec_id,
    output logic [31:0]      vec_addr
);
`ifdef INTC_NEST_EN
    localparam int DEPTH = STACK_DEPTH;
`else
    localparam int DEPTH = 1;
    localparam int unused_depth = STACK_DEPTH;
`endif
    localparam int SPW = $clog2(DEPTH + 1);

    typedef logic [N_SRC-1:0] vec_t;
    typedef enum logic {IDLE, REQ} state_t;

    state_t     state_q, state_d;
    vec_t       enable_q, mode_q, pending_q, prev_q, pending_d, inservice;
    vec_t       w1c, ack_clr, sel_mask;
    logic [4:0] stk_q [DEPTH];
    logic [SPW-1:0] sp_q;
    logic [4:0] cand_id, top_id;
    logic       cand_vld, eligible, held, ack, pop, load;
    logic       unused_wdata;

    assign unused_wdata = ^wdata;

    // Lowest-index enabled pending source wins.
    always_comb begin
        cand_vld = 1'b0;
        cand_id  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pending_q[i] & enable_q[i]) begin
                cand_vld = 1'b1;
                cand_id  = 5'(i);
            end
        end
    end

    always_comb begin
        top_id    = '0;
        inservice = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == int'(sp_q) - 1) top_id = stk_q[i];
            if (i < int'(sp_q))      inservice = inservice | (vec_t'(1) << stk_q[i]);
        end
    end

    // With a single slot, "not full" already implies an empty stack, so no preemption.
    assign eligible = cand_vld && (sp_q == '0 || cand_id < top_id) && (sp_q != SPW'(DEPTH));
    assign sel_mask = vec_t'(1) << vec_id;
    assign held     = |(pending_q & enable_q & sel_mask);
    assign ack      = (state_q == REQ) && inta;
    assign pop      = eret && (sp_q != '0);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: if (eligible) begin
                state_d = REQ;
                load    = 1'b1;
            end
            REQ:  if (inta || !held) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Edge sources: a fresh rising edge beats any clear in the same cycle.
    assign w1c       = (wen && addr == 2'd2) ? wdata[N_SRC-1:0] : '0;
    assign ack_clr   = ack ? sel_mask : '0;
    assign pending_d = (mode_q & ((pending_q & ~w1c & ~ack_clr) | (irq_in & ~prev_q)))
                     | (~mode_q & irq_in);

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q   <= IDLE;
            intr      <= 1'b0;
            vec_id    <= '0;
            vec_addr  <= VEC_BASE;
            enable_q  <= '0;
            mode_q    <= '0;
            pending_q <= '0;
            prev_q    <= '0;
        end else begin
            state_q   <= state_d;
            intr      <= (state_d == REQ);
            if (load) begin
                vec_id   <= cand_id;
                vec_addr <= VEC_BASE + (32'(cand_id) << VEC_SHIFT);
            end
            if (wen && addr == 2'd0) enable_q <= wdata[N_SRC-1:0];
            if (wen && addr == 2'd1) mode_q   <= wdata[N_SRC-1:0];
            pending_q <= pending_d;
            prev_q    <= irq_in;
        end
    end

    // Pop then push: a simultaneous inta/eret overwrites the top entry.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            sp_q <= '0;
            for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
        end else begin
            sp_q <= SPW'(int'(sp_q) - int'(pop) + int'(ack));
            for (int i = 0; i < DEPTH; i++) begin
                if (ack && i == int'(sp_q) - int'(pop)) stk_q[i] <= vec_id;
            end
        end
    end

    always_comb begin
        case (addr)
            2'd0:    rdata = 32'(enable_q);
            2'd1:    rdata = 32'(mode_q);
            2'd2:    rdata = 32'(pending_q);
            default: rdata = 32'(inservice);
        endcase
    end
endmodule
